// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode map, immediate format codes and packed immediate width
package riscv_pkg;
    localparam int IMM_W = 20;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;
    function automatic logic is_known_op(input logic [6:0] op);
        return op == OP_LOAD || op == OP_MISC_MEM || op == OP_OP_IMM || op == OP_AUIPC ||
               op == OP_STORE || op == OP_OP || op == OP_LUI || op == OP_BRANCH ||
               op == OP_JALR || op == OP_JAL || op == OP_SYSTEM;
    endfunction
endpackage

// File: rtl/imm_field_pack.sv
// imm_field_pack: classifies the immediate format and packs raw bits for the extender
module imm_field_pack
    import riscv_pkg::*;
#(
    parameter bit SUPPORT_CSR = 1'b1
) (
    input  logic [31:0] i_inst,
    output logic [19:0] o_imm_field,
    output logic        o_ext_op,
    output logic        o_unsigned_op,
    output logic [2:0]  o_imm_fmt,
    output logic        o_illegal
);
    logic [6:0] w_op;
    logic       w_known;
    assign w_op    = i_inst[6:0];
    assign w_known = (i_inst[1:0] == 2'b11) && is_known_op(w_op);
    always_comb begin
        o_imm_field   = '0;
        o_ext_op      = 1'b0;
        o_unsigned_op = 1'b0;
        o_imm_fmt     = FMT_NONE;
        o_illegal     = ~w_known;
        if (w_known) begin
            case (w_op)
                OP_LOAD, OP_OP_IMM, OP_JALR: begin
                    o_imm_fmt   = FMT_I;
                    o_imm_field = {8'h0, i_inst[31:20]};
                end
                OP_STORE: begin
                    o_imm_fmt   = FMT_S;
                    o_imm_field = {8'h0, i_inst[31:25], i_inst[11:7]};
                end
                OP_BRANCH: begin
                    o_imm_fmt   = FMT_B;
                    o_imm_field = {8'h0, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8]};
                end
                OP_LUI, OP_AUIPC: begin
                    o_imm_fmt   = FMT_U;
                    o_imm_field = i_inst[31:12];
                    o_ext_op    = 1'b1;
                end
                OP_JAL: begin
                    o_imm_fmt   = FMT_J;
                    o_imm_field = {i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21]};
                    o_ext_op    = 1'b1;
                end
                OP_SYSTEM: begin
                    // CSR*I carries a 5-bit zero-extended uimm in the rs1 slot
                    if (i_inst[14]) begin
                        if (SUPPORT_CSR) begin
                            o_imm_fmt     = FMT_Z;
                            o_imm_field   = {15'h0, i_inst[19:15]};
                            o_unsigned_op = 1'b1;
                        end else begin
                            o_illegal = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: one-deep IF->ID register stage with valid/ready handshake
// splitting RV32I fields and packing the immediate for the extender.
module instr_decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int IMM_W       = riscv_pkg::IMM_W,
    parameter bit SUPPORT_CSR = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       opcode,
    output logic [4:0]       rd_addr,
    output logic [2:0]       funct3,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    output logic [6:0]       funct7,
    output logic [IMM_W-1:0] imm_field,
    output logic             ext_op,
    output logic             unsigned_op,
    output logic [2:0]       imm_fmt,
    output logic             illegal
);
    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [31:0]      r_inst;
    logic [IMM_W-1:0] r_imm;
    logic             r_ext;
    logic             r_uns;
    logic [2:0]       r_fmt;
    logic             r_ill;
    logic [19:0]      w_imm;
    logic             w_ext;
    logic             w_uns;
    logic [2:0]       w_fmt;
    logic             w_ill;
    logic             w_xfer;

    imm_field_pack #(.SUPPORT_CSR(SUPPORT_CSR)) u_pack (
        .i_inst        (in_inst),
        .o_imm_field   (w_imm),
        .o_ext_op      (w_ext),
        .o_unsigned_op (w_uns),
        .o_imm_fmt     (w_fmt),
        .o_illegal     (w_ill)
    );

    assign in_ready = rst_n & ~flush & (~r_valid | out_ready);
    assign w_xfer   = in_valid & in_ready;

    // flush only clears valid; data regs keep the stale entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_inst  <= '0;
            r_imm   <= '0;
            r_ext   <= 1'b0;
            r_uns   <= 1'b0;
            r_fmt   <= FMT_NONE;
            r_ill   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_pc    <= in_pc;
            r_inst  <= in_inst;
            r_imm   <= w_imm;
            r_ext   <= w_ext;
            r_uns   <= w_uns;
            r_fmt   <= w_fmt;
            r_ill   <= w_ill;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign out_pc      = r_pc;
    assign opcode      = r_inst[6:0];
    assign rd_addr     = r_inst[11:7];
    assign funct3      = r_inst[14:12];
    assign rs1_addr    = r_inst[19:15];
    assign rs2_addr    = r_inst[24:20];
    assign funct7      = r_inst[31:25];
    assign imm_field   = r_imm;
    assign ext_op      = r_ext;
    assign unsigned_op = r_uns;
    assign imm_fmt     = r_fmt;
    assign illegal     = r_ill;
endmodule
